// File: rtl/fast_packet_decode_module_if.sv
// rtl/fast_packet_decode_module_if.sv - byte-in / field-out handshake bundle for the FAST packet decoder
interface fast_packet_decode_module_if #(
    parameter int MAX_FIELD_BYTES = 5
);
    logic [7:0]                   byte_in;
    logic                         byte_valid;
    logic                         byte_ready;
    logic [7*MAX_FIELD_BYTES-1:0] field_data;
    logic                         field_valid;
    logic                         out_ready;
    logic                         field_is_head;
    logic                         field_msg_last;
    logic [1:0]                   msg_index;

    modport master (
        output byte_in, byte_valid, out_ready,
        input  byte_ready, field_data, field_valid, field_is_head, field_msg_last, msg_index
    );

    modport slave (
        input  byte_in, byte_valid, out_ready,
        output byte_ready, field_data, field_valid, field_is_head, field_msg_last, msg_index
    );
endinterface

// File: rtl/fast_packet_decode_module.sv
// rtl/fast_packet_decode_module.sv - OPRA/FAST packet deframer and stop-bit field decoder
// Optional macro FAST_DEC_ERR_COUNT_EN builds a saturating 16-bit error counter on err_count.
module fast_packet_decode_module #(
    parameter int HEAD_BYTES      = 4,
    parameter int MAX_FIELD_BYTES = 5,
    parameter int MAX_MSGS        = 3,
    parameter int LEN_BITS        = 14
) (
    input  logic                            clk,
    input  logic                            rst_n,
    fast_packet_decode_module_if.slave      bus,
    output logic                            packet_done,
    output logic [1:0]                      msg_count,
    output logic                            err_pulse,
    output logic [2:0]                      err_code,
    output logic [15:0]                     err_count
);
    localparam int FW  = 7 * MAX_FIELD_BYTES;
    localparam int FCW = $clog2(MAX_FIELD_BYTES + 1);
    localparam int HCW = $clog2(HEAD_BYTES) + 1;
    localparam logic [FCW-1:0] FMAX  = FCW'(MAX_FIELD_BYTES);
    localparam logic [HCW-1:0] HLAST = HCW'(HEAD_BYTES - 1);
    localparam logic [1:0]     MMAX  = 2'(MAX_MSGS);
    localparam logic [7:0]     SOH   = 8'h01;
    localparam logic [7:0]     ETX   = 8'h03;

    typedef enum logic [2:0] {IDLE, HEAD, LEN, BODY, ERR} state_t;

    state_t              state, state_n;
    logic [FW-1:0]       acc, acc_n;
    logic [FCW-1:0]      fcnt, fcnt_n;
    logic [LEN_BITS-1:0] remaining, rem_n;
    logic [6:0]          len_hi, len_hi_n;
    logic                len_cnt, len_cnt_n;
    logic [HCW-1:0]      head_cnt, head_cnt_n;
    logic [1:0]          msg_cnt, msg_cnt_n;

    logic [FW-1:0]       fdata_q;
    logic                fvalid_q, fhead_q, flast_q;
    logic [1:0]          fidx_q;

    logic                take, stop;
    logic [7:0]          b;
    logic [FW-1:0]       acc_shift;
    logic [LEN_BITS-1:0] len_val, rem_dec;
    logic                emit, emit_head, emit_last, err_det, done;
    logic [FW-1:0]       emit_data;
    logic [2:0]          err_code_n;

    // IDLE and ERR never hold a pending field, so they always accept
    assign bus.byte_ready = (state == IDLE) || (state == ERR) || !fvalid_q || bus.out_ready;
    assign take      = bus.byte_valid && bus.byte_ready;
    assign b         = bus.byte_in;
    assign stop      = b[7];
    assign acc_shift = (acc << 7) | FW'(b[6:0]);
    assign len_val   = len_cnt ? LEN_BITS'({len_hi, b[6:0]}) : LEN_BITS'(b[6:0]);
    assign rem_dec   = remaining - LEN_BITS'(1);

    assign bus.field_data     = fdata_q;
    assign bus.field_valid    = fvalid_q;
    assign bus.field_is_head  = fhead_q;
    assign bus.field_msg_last = flast_q;
    assign bus.msg_index      = fidx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        fcnt_n     = fcnt;
        rem_n      = remaining;
        len_hi_n   = len_hi;
        len_cnt_n  = len_cnt;
        head_cnt_n = head_cnt;
        msg_cnt_n  = msg_cnt;
        emit       = 1'b0;
        emit_head  = 1'b0;
        emit_last  = 1'b0;
        emit_data  = '0;
        err_det    = 1'b0;
        err_code_n = 3'd0;
        done       = 1'b0;
        if (take) begin
            case (state)
                IDLE: begin
                    if (b == SOH) begin
                        state_n    = HEAD;
                        head_cnt_n = '0;
                        msg_cnt_n  = '0;
                    end
                end
                HEAD: begin
                    emit      = 1'b1;
                    emit_head = 1'b1;
                    emit_data = FW'(b);
                    if (head_cnt == HLAST) begin
                        state_n   = LEN;
                        len_cnt_n = 1'b0;
                    end else begin
                        head_cnt_n = head_cnt + HCW'(1);
                    end
                end
                LEN: begin
                    if (!len_cnt && b == ETX) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else if (!len_cnt && msg_cnt == MMAX) begin
                        err_det    = 1'b1;
                        err_code_n = 3'd4;
                    end else if (!stop) begin
                        if (len_cnt) begin
                            err_det    = 1'b1;
                            err_code_n = 3'd5;
                        end else begin
                            len_hi_n  = b[6:0];
                            len_cnt_n = 1'b1;
                        end
                    end else if (len_val == '0) begin
                        err_det    = 1'b1;
                        err_code_n = 3'd3;
                    end else begin
                        rem_n   = len_val;
                        acc_n   = '0;
                        fcnt_n  = '0;
                        state_n = BODY;
                    end
                end
                BODY: begin
                    rem_n = rem_dec;
                    if (fcnt == FMAX) begin
                        err_det    = 1'b1;
                        err_code_n = 3'd1;
                    end else if (!stop) begin
                        if (rem_dec == '0) begin
                            err_det    = 1'b1;
                            err_code_n = 3'd2;
                        end else begin
                            acc_n  = acc_shift;
                            fcnt_n = fcnt + FCW'(1);
                        end
                    end else begin
                        emit      = 1'b1;
                        emit_data = acc_shift;
                        acc_n     = '0;
                        fcnt_n    = '0;
                        if (rem_dec == '0) begin
                            emit_last = 1'b1;
                            msg_cnt_n = msg_cnt + 2'd1;
                            len_cnt_n = 1'b0;
                            state_n   = LEN;
                        end
                    end
                end
                ERR: begin
                    if (b == ETX) begin
                        state_n = IDLE;
                    end else if (b == SOH) begin
                        state_n    = HEAD;
                        head_cnt_n = '0;
                        msg_cnt_n  = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (err_det) state_n = ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            fcnt        <= '0;
            remaining   <= '0;
            len_hi      <= '0;
            len_cnt     <= 1'b0;
            head_cnt    <= '0;
            msg_cnt     <= '0;
            fdata_q     <= '0;
            fvalid_q    <= 1'b0;
            fhead_q     <= 1'b0;
            flast_q     <= 1'b0;
            fidx_q      <= '0;
            packet_done <= 1'b0;
            msg_count   <= '0;
            err_pulse   <= 1'b0;
            err_code    <= '0;
        end else begin
            acc         <= acc_n;
            fcnt        <= fcnt_n;
            remaining   <= rem_n;
            len_hi      <= len_hi_n;
            len_cnt     <= len_cnt_n;
            head_cnt    <= head_cnt_n;
            msg_cnt     <= msg_cnt_n;
            packet_done <= done;
            err_pulse   <= err_det;
            if (done)    msg_count <= msg_cnt;
            if (err_det) err_code  <= err_code_n;
            if (emit) begin
                fvalid_q <= 1'b1;
                fdata_q  <= emit_data;
                fhead_q  <= emit_head;
                flast_q  <= emit_last;
                fidx_q   <= msg_cnt;
            end else if (bus.out_ready) begin
                fvalid_q <= 1'b0;
            end
        end
    end

`ifdef FAST_DEC_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                err_count <= '0;
        else if (err_pulse && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_fast_packet_decode_module.sv
// tb/tb_fast_packet_decode_module.sv - scoreboard bench for the FAST packet decoder
module tb_fast_packet_decode_module;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        packet_done, err_pulse;
    logic [1:0]  msg_count;
    logic [2:0]  err_code;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int n_errs = 0;

    typedef struct {
        logic [34:0] data;
        logic        head;
        logic        last;
        logic [1:0]  idx;
    } fexp_t;

    fexp_t       exp_q[$];
    int          done_q[$];
    int          err_q[$];
    logic [7:0]  tx_q[$];

    fast_packet_decode_module_if #(.MAX_FIELD_BYTES(5)) bus ();

    fast_packet_decode_module dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .packet_done (packet_done),
        .msg_count   (msg_count),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_field(input logic [34:0] d, input logic h, input logic l, input logic [1:0] i);
        fexp_t e;
        e.data = d; e.head = h; e.last = l; e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic push_heads();
        push_field(35'h10, 1'b1, 1'b0, 2'd0);
        push_field(35'h20, 1'b1, 1'b0, 2'd0);
        push_field(35'h30, 1'b1, 1'b0, 2'd0);
        push_field(35'h40, 1'b1, 1'b0, 2'd0);
    endtask

    task automatic push_err(input int code);
        err_q.push_back(code);
        n_errs++;
    endtask

    // called just after a posedge; returns just after the posedge that took the byte
    task automatic send_byte(input logic [7:0] v);
        int n;
        bus.byte_in = v;
        bus.byte_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.byte_ready) break;
            n++;
            if (n > 200) begin
                check("byte_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_all();
        foreach (tx_q[k]) send_byte(tx_q[k]);
        bus.byte_valid = 1'b0;
        tx_q.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pkt_basic();
        push_heads();
        push_field(35'd5,   1'b0, 1'b0, 2'd0);
        push_field(35'd130, 1'b0, 1'b1, 2'd0);
        done_q.push_back(1);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h83, 8'h85, 8'h01, 8'h82, 8'h03};
        send_all();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.field_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_field", {29'd0, bus.field_data}, 64'd0);
                end else begin
                    fexp_t e;
                    e = exp_q.pop_front();
                    check("field_data", {29'd0, bus.field_data}, {29'd0, e.data});
                    check("field_is_head", 64'(bus.field_is_head), 64'(e.head));
                    check("field_msg_last", 64'(bus.field_msg_last), 64'(e.last));
                    check("msg_index", 64'(bus.msg_index), 64'(e.idx));
                end
            end
            if (packet_done) begin
                if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                else check("msg_count", 64'(msg_count), 64'(done_q.pop_front()));
            end
            if (err_pulse) begin
                if (err_q.size() == 0) check("unexpected_err", 64'(err_code), 64'd0);
                else check("err_code", 64'(err_code), 64'(err_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle_cycles(3);
        check("rst_field_valid", 64'(bus.field_valid), 64'd0);
        check("rst_byte_ready", 64'(bus.byte_ready), 64'd1);
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_field_valid", 64'(bus.field_valid), 64'd0);
        check("idle_err_code", 64'(err_code), 64'd0);
        check("idle_err_count", 64'(err_count), 64'd0);
        check("idle_msg_count", 64'(msg_count), 64'd0);

        pkt_basic();
        idle_cycles(4);

        // stall at the first body field
        fork
            pkt_basic();
            begin
                int w;
                w = 0;
                forever begin
                    @(posedge clk); #1;
                    if (bus.field_valid && !bus.field_is_head) break;
                    w++;
                    if (w > 200) begin
                        check("stall_wait_timeout", 64'd0, 64'd1);
                        break;
                    end
                end
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_byte_ready", 64'(bus.byte_ready), 64'd0);
                    check("stall_field_held", 64'(bus.field_valid), 64'd1);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        idle_cycles(4);

        // zero length, junk discarded to ETX, then a clean packet
        push_heads();
        push_err(3);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h80, 8'h55, 8'h66, 8'h03};
        send_all();
        idle_cycles(3);
        pkt_basic();
        idle_cycles(4);

        // six continuation bytes in one field
        push_heads();
        push_err(1);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h8A,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03};
        send_all();
        idle_cycles(4);

        // length runs out mid-field
        push_heads();
        push_err(2);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h82, 8'h05, 8'h06, 8'h87, 8'h03};
        send_all();
        idle_cycles(4);

        // fourth message exceeds the per-packet limit
        push_heads();
        push_field(35'd1, 1'b0, 1'b1, 2'd0);
        push_field(35'd2, 1'b0, 1'b1, 2'd1);
        push_field(35'd3, 1'b0, 1'b1, 2'd2);
        push_err(4);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40,
                 8'h81, 8'h81, 8'h81, 8'h82, 8'h81, 8'h83, 8'h81, 8'h84, 8'h03};
        send_all();
        idle_cycles(4);
        check("err_code_hold", 64'(err_code), 64'd4);

`ifdef FAST_DEC_ERR_COUNT_EN
        check("err_count", 64'(err_count), 64'(n_errs));
`else
        check("err_count_tied", 64'(err_count), 64'd0);
`endif

        // reset in the middle of a body field
        push_heads();
        push_field(35'd5, 1'b0, 1'b0, 2'd0);
        tx_q = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h83, 8'h85, 8'h01};
        send_all();
        rst_n = 1'b0;
        #1;
        check("async_field_valid", 64'(bus.field_valid), 64'd0);
        check("async_field_data", {29'd0, bus.field_data}, 64'd0);
        check("async_err_code", 64'(err_code), 64'd0);
        check("async_msg_count", 64'(msg_count), 64'd0);
        check("async_err_count", 64'(err_count), 64'd0);
        check("async_packet_done", 64'(packet_done), 64'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        pkt_basic();
        idle_cycles(6);

        check("fields_left", 64'(exp_q.size()), 64'd0);
        check("dones_left", 64'(done_q.size()), 64'd0);
        check("errs_left", 64'(err_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
